// File: rtl/ibex_pkg.sv
// Shared constants for the fetch path.
//   FETCH_BUS_W32/64 : legal fetch bus widths
//   OPCODE_C_UNCOMP  : low two bits marking a 32-bit (uncompressed) instruction
package ibex_pkg;

  localparam int unsigned FETCH_BUS_W32 = 32;
  localparam int unsigned FETCH_BUS_W64 = 64;

  localparam logic [1:0] OPCODE_C_UNCOMP = 2'b11;

  function automatic bit fetch_bus_width_ok(input int unsigned w);
    return (w == FETCH_BUS_W32) || (w == FETCH_BUS_W64);
  endfunction

endpackage

// File: rtl/ibex_fetch_align.sv
// Halfword selection and compressed/error decode for the fetch FIFO.
//   e0_*        : effective entry 0 (stored or bypassed)
//   e1_*        : effective entry 1, only its lowest halfword is ever needed
//   off_i       : halfword offset of the PC inside entry 0
//   valid_o     : a whole instruction is available
//   rdata_o     : {second, first} halfword
//   err_o / err_plus2_o : fetch error, and error located in the second half
//   compressed_o / spanning_o : decode info for the PC/pop logic
module ibex_fetch_align import ibex_pkg::*; #(
  parameter int unsigned BUS_WIDTH = 64,
  localparam int unsigned HW   = BUS_WIDTH / 16,
  localparam int unsigned OFFW = $clog2(HW)
) (
  input  logic                 e0_avail_i,
  input  logic [BUS_WIDTH-1:0] e0_data_i,
  input  logic                 e0_err_i,
  input  logic                 e1_avail_i,
  input  logic [15:0]          e1_hw0_i,
  input  logic                 e1_err_i,
  input  logic [OFFW-1:0]      off_i,
  output logic                 valid_o,
  output logic [31:0]          rdata_o,
  output logic                 err_o,
  output logic                 err_plus2_o,
  output logic                 compressed_o,
  output logic                 spanning_o
);

  logic [HW-1:0][15:0] hw;
  logic [OFFW-1:0]     off_nxt;
  logic [15:0]         first, second;

  assign hw      = e0_data_i;
  // Wraps at the last halfword; unused in that case (spanning selects E1).
  assign off_nxt = off_i + OFFW'(1);

  assign spanning_o   = (off_i == OFFW'(HW - 1));
  assign first        = hw[off_i];
  assign second       = spanning_o ? e1_hw0_i : hw[off_nxt];
  // An errored fetch is treated as uncompressed so the error covers both halves.
  assign compressed_o = (first[1:0] != OPCODE_C_UNCOMP) & ~e0_err_i;

  assign valid_o     = e0_avail_i & (compressed_o | ~spanning_o | e1_avail_i);
  assign rdata_o     = {second, first};
  assign err_o       = e0_err_i | (spanning_o & ~compressed_o & e1_err_i);
  assign err_plus2_o = spanning_o & e1_err_i & ~e0_err_i;

endmodule

// File: rtl/ibex_fetch_fifo_wide.sv
// Wide instruction fetch FIFO: stores BUS_WIDTH-bit fetch responses and
// hands out aligned 16/32-bit instructions, with zero-latency bypass.
//   clk_i, rst_ni     : clock, synchronous active-low reset
//   clear_i           : flush entries, load PC from in_addr_i
//   busy_o, level_o   : occupancy (registered flags only)
//   in_*              : fetch response
//   out_*             : instruction handshake, address and error flags
module ibex_fetch_fifo_wide import ibex_pkg::*; #(
  parameter int unsigned NUM_REQS  = 2,
  parameter int unsigned BUS_WIDTH = 64,
  parameter bit          ResetAll  = 1'b0,
  localparam int unsigned LVLW = $clog2(NUM_REQS + 2)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  output logic [NUM_REQS-1:0]  busy_o,
  output logic [LVLW-1:0]      level_o,
  input  logic                 in_valid_i,
  input  logic [31:0]          in_addr_i,
  input  logic [BUS_WIDTH-1:0] in_rdata_i,
  input  logic                 in_err_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [31:0]          out_addr_o,
  output logic [31:0]          out_rdata_o,
  output logic                 out_err_o,
  output logic                 out_err_plus2_o
);

  localparam int unsigned DEPTH = NUM_REQS + 1;
  localparam int unsigned HW    = BUS_WIDTH / 16;
  localparam int unsigned OFFW  = $clog2(HW);

  logic [DEPTH-1:0]                valid_q, valid_d, valid_s;
  logic [DEPTH-1:0][BUS_WIDTH-1:0] data_q, data_d, data_s;
  logic [DEPTH-1:0]                err_q, err_d, err_s;
  logic [31:1]                     addr_q, addr_d;

  logic [OFFW-1:0]      off;
  logic                 e0_avail, e0_err, e1_avail, e1_err;
  logic [BUS_WIDTH-1:0] e0_data;
  logic [15:0]          e1_hw0;
  logic                 compressed, spanning, hs, pop, push, prev;
  logic [OFFW:0]        consumed;
  logic                 unused_addr0;

  assign unused_addr0 = in_addr_i[0];

  assign off        = addr_q[OFFW:1];
  assign out_addr_o = {addr_q, 1'b0};

  // Bypass: incoming data stands in for the first missing entry.
  assign e0_avail = valid_q[0] | in_valid_i;
  assign e0_data  = valid_q[0] ? data_q[0] : in_rdata_i;
  assign e0_err   = valid_q[0] ? err_q[0]  : (in_valid_i & in_err_i);
  assign e1_avail = valid_q[1] | (valid_q[0] & in_valid_i);
  assign e1_hw0   = valid_q[1] ? data_q[1][15:0] : in_rdata_i[15:0];
  assign e1_err   = valid_q[1] ? err_q[1] : (valid_q[0] & in_valid_i & in_err_i);

  ibex_fetch_align #(.BUS_WIDTH(BUS_WIDTH)) u_align (
    .e0_avail_i   (e0_avail),
    .e0_data_i    (e0_data),
    .e0_err_i     (e0_err),
    .e1_avail_i   (e1_avail),
    .e1_hw0_i     (e1_hw0),
    .e1_err_i     (e1_err),
    .off_i        (off),
    .valid_o      (out_valid_o),
    .rdata_o      (out_rdata_o),
    .err_o        (out_err_o),
    .err_plus2_o  (out_err_plus2_o),
    .compressed_o (compressed),
    .spanning_o   (spanning)
  );

  assign hs       = out_valid_o & out_ready_i & ~clear_i;
  assign consumed = {1'b0, off} + ((OFFW+1)'(compressed ? 1 : 2));
  assign pop      = hs & (consumed >= (OFFW+1)'(HW));
  // A bypassed word that is popped in the same cycle has been fully used.
  assign push     = in_valid_i & ~(~valid_q[0] & pop);

  always_comb begin
    valid_s = valid_q;
    data_s  = data_q;
    err_s   = err_q;
    if (pop) begin
      for (int i = 0; i < int'(DEPTH) - 1; i++) begin
        valid_s[i] = valid_q[i+1];
        data_s[i]  = data_q[i+1];
        err_s[i]   = err_q[i+1];
      end
      valid_s[DEPTH-1] = 1'b0;
    end
    valid_d = valid_s;
    data_d  = data_s;
    err_d   = err_s;
    prev    = 1'b1;
    // Valid flags are contiguous from 0, so write the first free slot.
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (push && prev && !valid_s[i]) begin
        valid_d[i] = 1'b1;
        data_d[i]  = in_rdata_i;
        err_d[i]   = in_err_i;
      end
      prev = valid_s[i];
    end
    if (clear_i) valid_d = '0;
  end

  always_comb begin
    addr_d = addr_q;
    if (clear_i)  addr_d = in_addr_i[31:1];
    else if (hs)  addr_d = addr_q + 31'(compressed ? 1 : 2);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) valid_q <= '0;
    else         valid_q <= valid_d;
  end

  always_ff @(posedge clk_i) begin
    if (ResetAll && !rst_ni) begin
      data_q <= '0;
      err_q  <= '0;
      addr_q <= '0;
    end else begin
      data_q <= data_d;
      err_q  <= err_d;
      addr_q <= addr_d;
    end
  end

  always_comb begin
    level_o = '0;
    for (int i = 0; i < int'(DEPTH); i++) level_o = level_o + LVLW'(valid_q[i]);
  end

  assign busy_o = valid_q[DEPTH-1:1];

  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   !(in_valid_i && valid_q[DEPTH-1] && !clear_i))
    else $error("push into full fetch FIFO");

  assert property (@(posedge clk_i) fetch_bus_width_ok(BUS_WIDTH))
    else $error("illegal BUS_WIDTH");

endmodule

// File: tb/tb_ibex_fetch_fifo_wide.sv
module tb_ibex_fetch_fifo_wide;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default configuration: NUM_REQS=2, BUS_WIDTH=64, DEPTH=3.
  logic        clr, iv, ierr, rdy;
  logic [31:0] iaddr;
  logic [63:0] idata;
  logic [1:0]  busy, lvl;
  logic        ov, oerr, op2;
  logic [31:0] oaddr, ordata;

  ibex_fetch_fifo_wide dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clr), .busy_o(busy), .level_o(lvl),
    .in_valid_i(iv), .in_addr_i(iaddr), .in_rdata_i(idata), .in_err_i(ierr),
    .out_valid_o(ov), .out_ready_i(rdy), .out_addr_o(oaddr), .out_rdata_o(ordata),
    .out_err_o(oerr), .out_err_plus2_o(op2)
  );

  // Narrow configuration: NUM_REQS=1, BUS_WIDTH=32, all flops reset.
  logic        c2_clr, c2_iv, c2_ierr, c2_rdy;
  logic [31:0] c2_iaddr, c2_idata;
  logic [0:0]  c2_busy;
  logic [1:0]  c2_lvl;
  logic        c2_ov, c2_oerr, c2_op2;
  logic [31:0] c2_oaddr, c2_ordata;

  ibex_fetch_fifo_wide #(.NUM_REQS(1), .BUS_WIDTH(32), .ResetAll(1'b1)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(c2_clr), .busy_o(c2_busy), .level_o(c2_lvl),
    .in_valid_i(c2_iv), .in_addr_i(c2_iaddr), .in_rdata_i(c2_idata), .in_err_i(c2_ierr),
    .out_valid_o(c2_ov), .out_ready_i(c2_rdy), .out_addr_o(c2_oaddr), .out_rdata_o(c2_ordata),
    .out_err_o(c2_oerr), .out_err_plus2_o(c2_op2)
  );

  typedef struct packed {
    logic        clr, iv;
    logic [31:0] iaddr;
    logic [63:0] idata;
    logic        ierr, rdy;
    logic        ov;
    logic [31:0] oaddr, ordata, omask;
    logic        oerr, op2;
    logic [1:0]  lvl, busy;
  } vec_t;

  localparam logic [31:0] M16 = 32'h0000_FFFF;
  localparam logic [31:0] M32 = 32'hFFFF_FFFF;
  localparam int NV = 27;

  vec_t vecs [NV];
  int pass_cnt = 0;
  int total_cnt = 0;

  function automatic vec_t mk(logic c, logic v, logic [31:0] a, logic [63:0] d, logic e,
                              logic r, logic eov, logic [31:0] ea, logic [31:0] ed,
                              logic [31:0] m, logic ee, logic ep, logic [1:0] el,
                              logic [1:0] eb);
    vec_t t;
    t.clr = c; t.iv = v; t.iaddr = a; t.idata = d; t.ierr = e; t.rdy = r;
    t.ov = eov; t.oaddr = ea; t.ordata = ed; t.omask = m; t.oerr = ee; t.op2 = ep;
    t.lvl = el; t.busy = eb;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clr = 0; iv = 0; iaddr = 0; idata = 0; ierr = 0; rdy = 0;
  endtask

  initial begin
    // clr iv iaddr idata ierr rdy | ov oaddr ordata mask err p2 lvl busy
    // 0x100 word: 0x4105 (C), 0x4501 (C), 0x0000_0013 (32-bit), then pop
    vecs[0]  = mk(1,0,32'h100,64'h0,0,0,                   0,32'h0,  32'h0,        M16,0,0,0,2'b00);
    vecs[1]  = mk(0,1,32'h0,64'h0000_0013_4501_4105,0,0,   1,32'h100,32'h4105,     M16,0,0,0,2'b00);
    vecs[2]  = mk(0,0,32'h0,64'h0,0,1,                     1,32'h100,32'h4105,     M16,0,0,1,2'b00);
    vecs[3]  = mk(0,0,32'h0,64'h0,0,1,                     1,32'h102,32'h4501,     M16,0,0,1,2'b00);
    vecs[4]  = mk(0,0,32'h0,64'h0,0,1,                     1,32'h104,32'h0000_0013,M32,0,0,1,2'b00);
    vecs[5]  = mk(0,0,32'h0,64'h0,0,0,                     0,32'h0,  32'h0,        M16,0,0,0,2'b00);
    // Spanning at 0x106: waits for the second word
    vecs[6]  = mk(1,0,32'h106,64'h0,0,0,                   0,32'h0,  32'h0,        M16,0,0,0,2'b00);
    vecs[7]  = mk(0,1,32'h0,64'h0513_0000_0000_0000,0,1,   0,32'h0,  32'h0,        M16,0,0,0,2'b00);
    vecs[8]  = mk(0,0,32'h0,64'h0,0,1,                     0,32'h0,  32'h0,        M16,0,0,1,2'b00);
    vecs[9]  = mk(0,1,32'h0,64'h1111_2222_3333_0000,0,0,   1,32'h106,32'h0000_0513,M32,0,0,1,2'b00);
    vecs[10] = mk(0,0,32'h0,64'h0,0,1,                     1,32'h106,32'h0000_0513,M32,0,0,2,2'b01);
    vecs[11] = mk(0,0,32'h0,64'h0,0,0,                     1,32'h10A,32'h2222_3333,M32,0,0,1,2'b00);
    // Spanning with error only in the second word
    vecs[12] = mk(1,0,32'h106,64'h0,0,0,                   1,32'h10A,32'h2222_3333,M32,0,0,1,2'b00);
    vecs[13] = mk(0,1,32'h0,64'h0513_0000_0000_0000,0,0,   0,32'h0,  32'h0,        M16,0,0,0,2'b00);
    vecs[14] = mk(0,1,32'h0,64'h1111_2222_3333_0000,1,0,   1,32'h106,32'h0000_0513,M32,1,1,1,2'b00);
    vecs[15] = mk(0,0,32'h0,64'h0,0,1,                     1,32'h106,32'h0000_0513,M32,1,1,2,2'b01);
    vecs[16] = mk(0,0,32'h0,64'h0,0,0,                     1,32'h10A,32'h2222_3333,M32,1,0,1,2'b00);
    // Fill to DEPTH, then clear with a push that must be dropped
    vecs[17] = mk(1,0,32'h200,64'h0,0,0,                   1,32'h10A,32'h2222_3333,M32,1,0,1,2'b00);
    vecs[18] = mk(0,1,32'h0,64'h0000_0013_0000_0013,0,0,   1,32'h200,32'h0000_0013,M32,0,0,0,2'b00);
    vecs[19] = mk(0,1,32'h0,64'h1111_1111_1111_1111,0,0,   1,32'h200,32'h0000_0013,M32,0,0,1,2'b00);
    vecs[20] = mk(0,1,32'h0,64'h2222_2222_2222_2222,0,0,   1,32'h200,32'h0000_0013,M32,0,0,2,2'b01);
    vecs[21] = mk(1,1,32'h300,64'h4444_4444_4444_4444,0,0, 1,32'h200,32'h0000_0013,M32,0,0,3,2'b11);
    vecs[22] = mk(0,0,32'h0,64'h0,0,0,                     0,32'h0,  32'h0,        M16,0,0,0,2'b00);
    vecs[23] = mk(0,0,32'h0,64'h0,0,0,                     0,32'h0,  32'h0,        M16,0,0,0,2'b00);
    // Bypassed word consumed in full the same cycle is not stored
    vecs[24] = mk(1,0,32'h406,64'h0,0,0,                   0,32'h0,  32'h0,        M16,0,0,0,2'b00);
    vecs[25] = mk(0,1,32'h0,64'h0001_0000_0000_0000,0,1,   1,32'h406,32'h0001,     M16,0,0,0,2'b00);
    vecs[26] = mk(0,0,32'h0,64'h0,0,0,                     0,32'h0,  32'h0,        M16,0,0,0,2'b00);

    idle();
    c2_clr = 0; c2_iv = 0; c2_iaddr = 0; c2_idata = 0; c2_ierr = 0; c2_rdy = 0;

    // Reset
    tick(); tick();
    #4;
    chk("rst level", lvl, 2'd0);
    chk("rst busy", busy, 2'b00);
    chk("rst out_valid", ov, 1'b0);
    chk("rst2 level", c2_lvl, 2'd0);
    chk("rst2 addr", c2_oaddr, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      clr = vecs[i].clr; iv = vecs[i].iv; iaddr = vecs[i].iaddr;
      idata = vecs[i].idata; ierr = vecs[i].ierr; rdy = vecs[i].rdy;
      #4;
      chk($sformatf("v%0d out_valid", i), ov, vecs[i].ov);
      chk($sformatf("v%0d level", i), lvl, vecs[i].lvl);
      chk($sformatf("v%0d busy", i), busy, vecs[i].busy);
      if (vecs[i].ov) begin
        chk($sformatf("v%0d addr", i), oaddr, vecs[i].oaddr);
        chk($sformatf("v%0d rdata", i), ordata & vecs[i].omask, vecs[i].ordata);
        chk($sformatf("v%0d err", i), oerr, vecs[i].oerr);
        chk($sformatf("v%0d err_plus2", i), op2, vecs[i].op2);
      end
      tick();
    end

    // Reset with two entries and the PC mid-entry
    idle(); clr = 1; iaddr = 32'h100; tick();
    idle(); iv = 1; idata = 64'h0000_0013_4501_4105; tick();
    tick();
    idle(); rdy = 1; #4;
    chk("mid rdata", ordata & M16, 32'h4105);
    tick();
    idle(); #4;
    chk("mid level", lvl, 2'd2);
    chk("mid addr", oaddr, 32'h102);
    rst_n = 1'b0;
    tick();
    #4;
    chk("mid rst level", lvl, 2'd0);
    chk("mid rst busy", busy, 2'b00);
    chk("mid rst out_valid", ov, 1'b0);
    rst_n = 1'b1;
    tick();

    // 32-bit bus, PC wrap. At 0xFFFF_FFFE the offset selects the upper
    // halfword (0x0001, compressed); the next fetch at 0x0 yields 0x4105.
    c2_clr = 1; c2_iaddr = 32'hFFFF_FFFE; tick();
    c2_clr = 0; c2_iv = 1; c2_idata = 32'h0001_4105; c2_rdy = 1; #4;
    chk("wrap valid", c2_ov, 1'b1);
    chk("wrap addr", c2_oaddr, 32'hFFFF_FFFE);
    chk("wrap rdata", c2_ordata & M16, 32'h0001);
    tick();
    c2_rdy = 0; #4;
    chk("wrap addr0", c2_oaddr, 32'h0);
    chk("wrap level", c2_lvl, 2'd0);
    chk("wrap rdata0", c2_ordata & M16, 32'h4105);
    tick();
    c2_iv = 0; #4;
    chk("wrap stored level", c2_lvl, 2'd1);
    chk("wrap busy", c2_busy, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
